// File: rtl/sdram_line_cache.sv
// rtl/sdram_line_cache.sv - direct-mapped read-only line cache between a 16-bit ROM client and the SDRAM controller
`timescale 1ns/1ps
module sdram_line_cache #(
   parameter int IDX_W  = 4,
   parameter int ADDR_W = 25
) (
   input  logic              clk,
   input  logic              init,
   input  logic              flush,
   input  logic              req,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              busy,
   output logic              rd_valid,
   output logic [15:0]       rd_data,
   output logic [ADDR_W-1:0] sdr_addr,
   output logic              sdr_rd,
   output logic              sdr_rd_type,
   input  logic [63:0]       sdr_dout,
   input  logic              sdr_ready
);
   localparam int LINES = 1 << IDX_W;
   localparam int TAG_W = ADDR_W - IDX_W - 3;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_LOW  = 3'd2,
      S_WAIT_HIGH = 3'd3,
      S_FILL      = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              busy_q, busy_d;
   logic              rd_valid_q, rd_valid_d;
   logic [15:0]       rd_data_q, rd_data_d;
   logic [ADDR_W-1:0] sdr_addr_q, sdr_addr_d;
   logic              sdr_rd_q, sdr_rd_d;
   logic [1:0]        tmo_q, tmo_d;
   logic              flushed_q, flushed_d;
   logic [ADDR_W-2:0] addr_q, addr_d;
   logic [LINES-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0]  tag_q [LINES];
   logic [TAG_W-1:0]  tag_d [LINES];
   logic [63:0]       data_q [LINES];
   logic [63:0]       data_d [LINES];

   logic [1:0]        req_word, fill_word;
   logic [IDX_W-1:0]  req_idx, fill_idx;
   logic [TAG_W-1:0]  req_tag, fill_tag;
   logic              req_hit;
   logic              unused_addr0;

   assign req_word  = req_addr[2:1];
   assign req_idx   = req_addr[IDX_W+2:3];
   assign req_tag   = req_addr[ADDR_W-1:IDX_W+3];
   // addr_q holds the word address, so every field sits one bit lower
   assign fill_word = addr_q[1:0];
   assign fill_idx  = addr_q[IDX_W+1:2];
   assign fill_tag  = addr_q[ADDR_W-2:IDX_W+2];
   assign req_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !flush;
   assign unused_addr0 = req_addr[0];

   function automatic logic [15:0] pick_word(input logic [63:0] line, input logic [1:0] w);
      case (w)
         2'd0:    return line[63:48];
         2'd1:    return line[47:32];
         2'd2:    return line[31:16];
         default: return line[15:0];
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (init) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         sdr_addr_q <= '0;
         sdr_rd_q   <= 1'b0;
         tmo_q      <= '0;
         flushed_q  <= 1'b0;
         addr_q     <= '0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         sdr_addr_q <= sdr_addr_d;
         sdr_rd_q   <= sdr_rd_d;
         tmo_q      <= tmo_d;
         flushed_q  <= flushed_d;
         addr_q     <= addr_d;
         valid_q    <= valid_d;
      end
      if (!init) begin
         tag_q  <= tag_d;
         data_q <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (req && !req_hit) state_d = S_ISSUE;
         S_ISSUE:     state_d = S_WAIT_LOW;
         // ready never dropping means the controller served the line from its last burst
         S_WAIT_LOW: begin
            if (!sdr_ready)          state_d = S_WAIT_HIGH;
            else if (tmo_q == 2'd2)  state_d = S_FILL;
         end
         S_WAIT_HIGH: if (sdr_ready) state_d = S_FILL;
         S_FILL:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_d     = busy_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      sdr_addr_d = sdr_addr_q;
      sdr_rd_d   = sdr_rd_q;
      tmo_d      = tmo_q;
      flushed_d  = flushed_q;
      addr_d     = addr_q;
      valid_d    = valid_q;
      tag_d      = tag_q;
      data_d     = data_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d = req_addr[ADDR_W-1:1];
               if (req_hit) begin
                  rd_data_d  = pick_word(data_q[req_idx], req_word);
                  rd_valid_d = 1'b1;
               end else begin
                  busy_d     = 1'b1;
                  sdr_addr_d = {req_addr[ADDR_W-1:3], 3'b000};
                  flushed_d  = 1'b0;
               end
            end
         end
         S_ISSUE: begin
            sdr_rd_d = 1'b1;
            tmo_d    = '0;
         end
         S_WAIT_LOW: if (sdr_ready) tmo_d = tmo_q + 2'd1;
         S_FILL: begin
            data_d[fill_idx]  = sdr_dout;
            tag_d[fill_idx]   = fill_tag;
            valid_d[fill_idx] = !flushed_q;
            rd_data_d         = pick_word(sdr_dout, fill_word);
            rd_valid_d        = 1'b1;
            sdr_rd_d          = 1'b0;
            busy_d            = 1'b0;
         end
         default: ;
      endcase
      // a flush seen mid-miss must keep the pending line from becoming valid
      if (flush) begin
         valid_d = '0;
         if (state_q != S_IDLE) flushed_d = 1'b1;
      end
   end

   assign busy        = busy_q;
   assign rd_valid    = rd_valid_q;
   assign rd_data     = rd_data_q;
   assign sdr_addr    = sdr_addr_q;
   assign sdr_rd      = sdr_rd_q;
   assign sdr_rd_type = 1'b1;
endmodule

// File: tb/tb_sdram_line_cache.sv
// tb/tb_sdram_line_cache.sv - scoreboard bench for sdram_line_cache with an SDRAM responder model
`timescale 1ns/1ps
module tb_sdram_line_cache;
   logic        clk = 1'b0;
   logic        init, flush, req;
   logic [24:0] req_addr;
   logic        busy, rd_valid, sdr_rd, sdr_rd_type, sdr_ready;
   logic [15:0] rd_data;
   logic [24:0] sdr_addr;
   logic [63:0] sdr_dout;

   sdram_line_cache #(.IDX_W(4), .ADDR_W(25)) dut (
      .clk(clk), .init(init), .flush(flush), .req(req), .req_addr(req_addr),
      .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data),
      .sdr_addr(sdr_addr), .sdr_rd(sdr_rd), .sdr_rd_type(sdr_rd_type),
      .sdr_dout(sdr_dout), .sdr_ready(sdr_ready)
   );

   always #5 clk = ~clk;

   int          n_vec = 0, n_err = 0;
   int          bursts = 0, exp_bursts = 0;
   logic [15:0] exp_q[$];
   logic [24:0] exp_addr_q[$];
   bit          mvalid [16];
   logic [17:0] mtag [16];
   logic [63:0] mem [logic [21:0]];
   bit          shortcut = 1'b0;
   int          lat = 3;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic bad(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: event occurred, required none", name);
   endtask

   function automatic logic [63:0] line_of(input logic [24:0] a);
      logic [21:0] k;
      k = a[24:3];
      if (mem.exists(k)) return mem[k];
      return {k[15:0] ^ 16'h5a5a, k[15:0] + 16'h1357, ~k[15:0], {k[21:16], k[9:0]} ^ 16'h0f0f};
   endfunction

   function automatic logic [15:0] word_of(input logic [63:0] l, input logic [1:0] w);
      return 16'(l >> (16 * (3 - int'(w))));
   endfunction

   task automatic model_flush();
      foreach (mvalid[i]) mvalid[i] = 1'b0;
   endtask

   // SDRAM responder: ready drops right after each rising sdr_rd, returns after lat cycles
   initial begin
      int          cnt;
      bit          prev;
      cnt = 0;
      prev = 1'b0;
      sdr_ready = 1'b1;
      sdr_dout = '0;
      forever begin
         @(posedge clk); #2;
         if (sdr_rd === 1'b1 && !prev) begin
            bursts++;
            if (exp_addr_q.size() == 0) bad("unexpected_burst");
            else chk("sdr_addr", sdr_addr, exp_addr_q.pop_front());
            if (!init) begin
               if (shortcut) sdr_dout = line_of(sdr_addr);
               else begin
                  sdr_ready = 1'b0;
                  cnt = lat;
               end
            end
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               sdr_dout = line_of(sdr_addr);
               sdr_ready = 1'b1;
            end
         end
         if (init) begin
            cnt = 0;
            sdr_ready = 1'b1;
         end
         prev = (sdr_rd === 1'b1);
      end
   end

   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (exp_q.size() == 0) bad("spurious_rd_valid");
         else chk("rd_data", rd_data, exp_q.pop_front());
         chk("busy_at_rd_valid", busy, 1'b0);
      end
   end

   task automatic do_req(input logic [24:0] a, input bit fl, input int fl_at, input int ig_at);
      logic [3:0]  idx;
      logic [17:0] tg;
      bit          hit;
      int          i;
      idx = a[6:3];
      tg  = a[24:7];
      if (fl) model_flush();
      hit = mvalid[idx] && (mtag[idx] == tg);
      exp_q.push_back(word_of(line_of(a), a[2:1]));
      if (!hit) begin
         exp_bursts++;
         exp_addr_q.push_back({a[24:3], 3'b000});
         mvalid[idx] = 1'b1;
         mtag[idx]   = tg;
      end
      req = 1'b1; req_addr = a; flush = fl;
      @(posedge clk); #1;
      req = 1'b0; flush = 1'b0;
      if (!hit) begin
         chk("busy_after_miss", busy, 1'b1);
         i = 0;
         while (busy === 1'b1 && i < 300) begin
            if (i == fl_at) begin
               flush = 1'b1;
               model_flush();
            end
            if (i == ig_at) begin
               req = 1'b1;
               req_addr = 25'($urandom);
            end
            @(posedge clk); #1;
            flush = 1'b0; req = 1'b0;
            i++;
         end
         if (busy !== 1'b0) bad("miss_timeout");
      end
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      model_flush();
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [24:0] a;
      init = 1'b1; flush = 1'b0; req = 1'b0; req_addr = '0;
      mem[22'h000020] = 64'h1111_2222_3333_4444;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 1'b0);
      chk("reset_rd_valid", rd_valid, 1'b0);
      chk("reset_rd_data", rd_data, 16'h0);
      chk("reset_sdr_rd", sdr_rd, 1'b0);
      chk("reset_sdr_addr", sdr_addr, 25'h0);
      chk("rd_type", sdr_rd_type, 1'b1);
      init = 1'b0;
      @(posedge clk); #1;

      do_req(25'h000100, 0, -1, -1);
      do_req(25'h000106, 0, -1, -1);
      chk("t1_bursts", bursts, 1);

      do_req(25'h000100, 0, -1, -1);
      do_req(25'h000102, 0, -1, -1);
      do_req(25'h000104, 0, -1, -1);
      do_req(25'h000106, 0, -1, -1);
      chk("t2_bursts", bursts, 1);

      do_req(25'h000180, 0, -1, -1);
      do_req(25'h000100, 0, -1, -1);
      chk("t3_bursts", bursts, 3);

      pulse_flush();
      shortcut = 1'b1;
      do_req(25'h000102, 0, -1, -1);
      shortcut = 1'b0;
      do_req(25'h000104, 0, -1, -1);
      chk("t4_bursts", bursts, 4);

      lat = 6;
      do_req(25'h000208, 0, 3, -1);
      do_req(25'h000208, 0, -1, -1);
      chk("t5_bursts", bursts, 6);

      lat = 3;
      exp_q.push_back(word_of(line_of(25'h000210), 2'd0));
      exp_bursts++;
      exp_addr_q.push_back(25'h000210);
      req = 1'b1; req_addr = 25'h000210;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      chk("t6_sdr_rd_before_init", sdr_rd, 1'b1);
      init = 1'b1;
      void'(exp_q.pop_back());
      @(posedge clk); #1;
      init = 1'b0;
      chk("t6_sdr_rd", sdr_rd, 1'b0);
      chk("t6_busy", busy, 1'b0);
      model_flush();
      repeat (6) @(posedge clk);
      #1;
      do_req(25'h000210, 0, -1, -1);
      do_req(25'h000102, 0, -1, -1);
      chk("t6_bursts", bursts, 9);

      for (int n = 0; n < 400; n++) begin
         a = {7'd0, 11'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
         if ($urandom % 8 == 0) a[24:7] = 18'($urandom);
         shortcut = ($urandom % 5 == 0);
         lat = $urandom_range(1, 6);
         do_req(a, ($urandom % 12 == 0),
                ($urandom % 5 == 0) ? int'($urandom_range(0, 10)) : -1,
                ($urandom % 4 == 0) ? int'($urandom_range(0, 6)) : -1);
         if ($urandom % 4 == 0) begin
            @(posedge clk); #1;
         end
      end
      shortcut = 1'b0;

      for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
         @(posedge clk); #1;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      chk("total_bursts", bursts, exp_bursts);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
